inv_rotate: RTL and testbench
=============================

Name: inv_rotate

Overview:
- Inverse of the DCT lifting rotation: rotates the pair (y1, y2) by -Angle using three quantized lifting steps applied in reverse order (tan, sin, tan).
- Uses exactly the same quantized constants and truncating multiply as the forward rotator. Any forward-rotated pair is therefore restored bit-exactly, including modulo-2^Width wrap.
- Sits in the IDCT datapath as the butterfly counterpart of the forward rotate stage. AXI-stream style valid/ready with side data.

Parameters:
- Width, 16, signed sample width of y1/y2/x1/x2.
- Point, 8, fractional bits of the lifting constants.
- Angle, 0.0, real, forward rotation angle in radians; this block undoes it.
- SideDataWidth, 1, width of the pass-through side data; must be >= 1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s_ready_o  out  1  input ready, driven directly from a register.
- s_valid_i  in  1  input beat valid.
- s_y1_i  in  Width  signed rotated sample 1.
- s_y2_i  in  Width  signed rotated sample 2.
- s_side_data_i  in  SideDataWidth  opaque tag travelling with the beat.
- m_ready_i  in  1  downstream ready.
- m_valid_o  out  1  output beat valid.
- m_x1_o  out  Width  signed restored sample 1.
- m_x2_o  out  Width  signed restored sample 2.
- m_side_data_o  out  SideDataWidth  tag of the output beat.

Behaviour:
- Constants: Tan = $rtoi($tan(Angle/2)*2^Point), Sin = $rtoi($sin(Angle)*2^Point), held as signed Width.
- M(a,b) = full 2*Width signed product, arithmetic shift right by Point (floor), truncated to Width.
- All add/sub wrap modulo 2^Width.
- Transfer occurs on a cycle where valid && ready. While valid && !ready, data and side data hold stable.
- Input stage: 2-entry skid buffer (main + skid).
  - s_ready_o = skid entry empty, registered.
  - Accepts while main is full and downstream is stalled; s_ready_o falls the cycle after the skid entry fills.
- Stage 1 register: u1 = y1 - M(y2,Tan); u2 = y2.
- Stage 2 register: v1 = u1; v2 = u2 + M(u1,Sin).
- Stage 3 register (drives the outputs): x1 = v1 - M(v2,Tan); x2 = v2.
- Stage handshake: ready_k = !valid_k || ready_(k+1), where ready after stage 3 is m_ready_i. Stage k loads when valid_(k-1) && ready_k and clears valid when its beat leaves without a replacement.
- Side data follows its beat unchanged through every register; it is never reordered.
- Latency: 4 cycles from input handshake to m_valid_o when unstalled. Throughput: 1 beat/cycle with m_ready_i held high.
- Capacity: 5 beats (2 in the skid buffer + 3 stages). No beat is dropped or duplicated under any ready/valid pattern.
- Reset (any cycle, including mid-stream):
  - All valids 0, s_ready_o = 1, m_valid_o = 0; data registers retain their values, don't care.
  - Handshakes in a cycle with rst_i = 1 are ignored.
  - In-flight beats are discarded.
- Angle = 0 gives Tan = Sin = 0: pure 4-cycle delay.

Decomposition:
- Shared package dct2_pkg:
  - function for the lifting constants (Tan, Sin from Angle, Point, Width);
  - function Mult(a, b) with the exact truncation rule above, also used by the forward rotator so rounding cannot diverge.
- One natural sub-module: lifting_stage, a single-entry valid/ready register parameterized by operation (add or subtract of M(src, K) onto one lane), instantiated 3 times. The skid buffer is the existing codebase AxisReg with Pipelined = 1.

Test Plan:
(Width 16, Point 8, Angle pi/4, so Tan = 106, Sin = 181.)
- Basic: y = (256, 0) -> x = (182, 181), 4 cycles after the handshake, side data 1 preserved.
- Negative floor rounding: y = (0, -1) -> x = (2, -1).
- Wrap: y = (32767, 32767) -> x = (27148, -19194); the stage-2 v2 value must wrap to -19194.
- Round trip: 10k random pairs through forward rotate then inv_rotate (random m_ready_i/s_valid_i) -> output equals original input bit-exactly, order and side data preserved.
- Backpressure: m_ready_i = 0 from reset, s_valid_i = 1 with 8 distinct beats -> exactly 5 accepted, s_ready_o low the cycle after the 5th. Then m_ready_i = 1 -> the 5 beats emerge in order on consecutive cycles, followed by the remaining 3.
- Reset mid-stream: assert rst_i for 1 cycle with 3 beats in flight -> next cycle m_valid_o = 0, s_ready_o = 1; those 3 beats never appear; a new beat has latency 4.

Source files
------------

// File: rtl/dct2_pkg.sv
// Shared lifting helpers for the DCT rotators: quantized constants and the
// truncating fixed-point multiply used by both the forward and inverse stages.
package dct2_pkg;

    function automatic int lift_tan(input real angle, input int point);
        return $rtoi($tan(angle / 2.0) * (2.0 ** point));
    endfunction

    function automatic int lift_sin(input real angle, input int point);
        return $rtoi($sin(angle) * (2.0 ** point));
    endfunction

    // Full signed product, then floor shift; callers truncate to their sample width.
    function automatic logic signed [63:0] lift_mult(input logic signed [31:0] a,
                                                     input logic signed [31:0] b,
                                                     input int point);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return prod >>> point;
    endfunction

endpackage

// File: rtl/lifting_stage.sv
// Single-entry valid/ready register applying one lifting step:
// one lane gets +/- M(other lane, K), the other lane passes through.
module lifting_stage
    import dct2_pkg::*;
#(
    parameter int                      Width         = 16,
    parameter int                      Point         = 8,
    parameter int                      SideDataWidth = 1,
    parameter logic signed [Width-1:0] K             = '0,
    parameter bit                      UpdateLane2   = 1'b0,
    parameter bit                      Subtract      = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic signed [Width-1:0]  up_x1,
    input  logic signed [Width-1:0]  up_x2,
    input  logic [SideDataWidth-1:0] up_side,
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic signed [Width-1:0]  dn_x1,
    output logic signed [Width-1:0]  dn_x2,
    output logic [SideDataWidth-1:0] dn_side
);

    logic signed [Width-1:0] src;
    logic signed [Width-1:0] target;
    logic signed [Width-1:0] term;
    logic signed [Width-1:0] upd;

    assign up_ready = !dn_valid || dn_ready;

    always_comb begin
        src    = UpdateLane2 ? up_x1 : up_x2;
        target = UpdateLane2 ? up_x2 : up_x1;
        term   = Width'(lift_mult(32'(src), 32'(K), Point));
        upd    = Subtract ? target - term : target + term;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
        end
    end

    // Payload is not reset; it is only meaningful while dn_valid is set.
    always_ff @(posedge clk_i) begin
        if (up_valid && up_ready) begin
            dn_x1   <= UpdateLane2 ? up_x1 : upd;
            dn_x2   <= UpdateLane2 ? upd : up_x2;
            dn_side <= up_side;
        end
    end

endmodule

// File: rtl/inv_rotate.sv
// Inverse DCT lifting rotation: undoes the forward rotator bit-exactly with
// lifting steps tan, sin, tan behind a registered-ready two-entry skid buffer.
module inv_rotate
    import dct2_pkg::*;
#(
    parameter int  Width         = 16,
    parameter int  Point         = 8,
    parameter real Angle         = 0.0,
    parameter int  SideDataWidth = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     s_ready_o,
    input  logic                     s_valid_i,
    input  logic signed [Width-1:0]  s_y1_i,
    input  logic signed [Width-1:0]  s_y2_i,
    input  logic [SideDataWidth-1:0] s_side_data_i,
    input  logic                     m_ready_i,
    output logic                     m_valid_o,
    output logic signed [Width-1:0]  m_x1_o,
    output logic signed [Width-1:0]  m_x2_o,
    output logic [SideDataWidth-1:0] m_side_data_o
);

    localparam logic signed [Width-1:0] Tan = Width'(lift_tan(Angle, Point));
    localparam logic signed [Width-1:0] Sin = Width'(lift_sin(Angle, Point));

    logic                     ready_q;
    logic                     accept;
    logic                     main_valid, main_valid_nx;
    logic                     skid_valid, skid_valid_nx;
    logic                     main_ready;
    logic signed [Width-1:0]  main_y1, main_y2, main_y1_nx, main_y2_nx;
    logic signed [Width-1:0]  skid_y1, skid_y2, skid_y1_nx, skid_y2_nx;
    logic [SideDataWidth-1:0] main_side, main_side_nx, skid_side, skid_side_nx;

    assign accept    = s_valid_i && ready_q;
    assign s_ready_o = ready_q;

    // Skid only fills when main is occupied and stage 1 is stalled.
    always_comb begin
        main_valid_nx = main_valid;
        skid_valid_nx = skid_valid;
        main_y1_nx    = main_y1;
        main_y2_nx    = main_y2;
        main_side_nx  = main_side;
        skid_y1_nx    = skid_y1;
        skid_y2_nx    = skid_y2;
        skid_side_nx  = skid_side;
        if (!main_valid || main_ready) begin
            if (skid_valid) begin
                main_valid_nx = 1'b1;
                skid_valid_nx = 1'b0;
                main_y1_nx    = skid_y1;
                main_y2_nx    = skid_y2;
                main_side_nx  = skid_side;
            end else begin
                main_valid_nx = accept;
                if (accept) begin
                    main_y1_nx   = s_y1_i;
                    main_y2_nx   = s_y2_i;
                    main_side_nx = s_side_data_i;
                end
            end
        end else if (accept) begin
            skid_valid_nx = 1'b1;
            skid_y1_nx    = s_y1_i;
            skid_y2_nx    = s_y2_i;
            skid_side_nx  = s_side_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= main_valid_nx;
            skid_valid <= skid_valid_nx;
            ready_q    <= !skid_valid_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        main_y1   <= main_y1_nx;
        main_y2   <= main_y2_nx;
        main_side <= main_side_nx;
        skid_y1   <= skid_y1_nx;
        skid_y2   <= skid_y2_nx;
        skid_side <= skid_side_nx;
    end

    logic                     u_valid, u_ready, v_valid, v_ready;
    logic signed [Width-1:0]  u_x1, u_x2, v_x1, v_x2;
    logic [SideDataWidth-1:0] u_side, v_side;

    lifting_stage #(
        .Width(Width), .Point(Point), .SideDataWidth(SideDataWidth),
        .K(Tan), .UpdateLane2(1'b0), .Subtract(1'b1)
    ) u_stage1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .up_valid(main_valid),
        .up_ready(main_ready),
        .up_x1   (main_y1),
        .up_x2   (main_y2),
        .up_side (main_side),
        .dn_valid(u_valid),
        .dn_ready(u_ready),
        .dn_x1   (u_x1),
        .dn_x2   (u_x2),
        .dn_side (u_side)
    );

    lifting_stage #(
        .Width(Width), .Point(Point), .SideDataWidth(SideDataWidth),
        .K(Sin), .UpdateLane2(1'b1), .Subtract(1'b0)
    ) u_stage2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .up_valid(u_valid),
        .up_ready(u_ready),
        .up_x1   (u_x1),
        .up_x2   (u_x2),
        .up_side (u_side),
        .dn_valid(v_valid),
        .dn_ready(v_ready),
        .dn_x1   (v_x1),
        .dn_x2   (v_x2),
        .dn_side (v_side)
    );

    lifting_stage #(
        .Width(Width), .Point(Point), .SideDataWidth(SideDataWidth),
        .K(Tan), .UpdateLane2(1'b0), .Subtract(1'b1)
    ) u_stage3 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .up_valid(v_valid),
        .up_ready(v_ready),
        .up_x1   (v_x1),
        .up_x2   (v_x2),
        .up_side (v_side),
        .dn_valid(m_valid_o),
        .dn_ready(m_ready_i),
        .dn_x1   (m_x1_o),
        .dn_x2   (m_x2_o),
        .dn_side (m_side_data_o)
    );

endmodule

// File: tb/tb_inv_rotate.sv
// Directed and round-trip bench for inv_rotate with a queue scoreboard.
module tb_inv_rotate;

    localparam int      SDW   = 8;
    localparam real     ANGLE = 3.14159265358979323846 / 4.0;
    localparam shortint TAN   = 106;
    localparam shortint SIN   = 181;

    typedef struct packed {
        logic [15:0] x1;
        logic [15:0] x2;
        logic [7:0]  side;
        logic [31:0] stamp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_ready;
    logic              s_valid = 1'b0;
    logic signed [15:0] s_y1 = '0, s_y2 = '0;
    logic [SDW-1:0]    s_side = '0;
    logic              m_ready;
    logic              m_valid;
    logic signed [15:0] m_x1, m_x2;
    logic [SDW-1:0]    m_side;

    logic ready_val  = 1'b1;
    logic rand_ready = 1'b0;
    logic rand_bit   = 1'b1;
    logic lat_chk    = 1'b1;
    assign m_ready = rand_ready ? rand_bit : ready_val;

    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   n_in = 0;
    int   n_out = 0;
    exp_t next_exp = '0;
    exp_t sb[$];
    int   out_cycs[$];

    inv_rotate #(
        .Width(16), .Point(8), .Angle(ANGLE), .SideDataWidth(SDW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_ready_o    (s_ready),
        .s_valid_i    (s_valid),
        .s_y1_i       (s_y1),
        .s_y2_i       (s_y2),
        .s_side_data_i(s_side),
        .m_ready_i    (m_ready),
        .m_valid_o    (m_valid),
        .m_x1_o       (m_x1),
        .m_x2_o       (m_x2),
        .m_side_data_o(m_side)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rand_bit = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic shortint mq(input shortint a, input shortint b);
        longint p;
        p = longint'(a) * longint'(b);
        return shortint'(p >>> 8);
    endfunction

    function automatic exp_t lit(input shortint a, input shortint b, input logic [7:0] s);
        return {a, b, s, 32'd0};
    endfunction

    function automatic exp_t inv_model(input shortint y1, input shortint y2, input logic [7:0] s);
        shortint u1, v2, x1;
        u1 = y1 - mq(y2, TAN);
        v2 = y2 + mq(u1, SIN);
        x1 = u1 - mq(v2, TAN);
        return {x1, v2, s, 32'd0};
    endfunction

    task automatic fwd(input shortint x1, input shortint x2, output shortint y1, output shortint y2);
        shortint u1, v2;
        u1 = x1 + mq(x2, TAN);
        v2 = x2 - mq(u1, SIN);
        y1 = u1 + mq(v2, TAN);
        y2 = v2;
    endtask

    // Scoreboard: push at input handshake, pop and compare at output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (s_valid && s_ready) begin
                e = next_exp;
                e.stamp = cyc;
                sb.push_back(e);
                n_in++;
            end
            if (m_valid && m_ready) begin
                n_out++;
                out_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_beat", {m_x1, m_x2, m_side}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat", {m_x1, m_x2, m_side}, {e.x1, e.x2, e.side});
                    if (lat_chk) check("latency", cyc - int'(e.stamp), 4);
                end
            end
        end
    end

    task automatic drive(input shortint y1, input shortint y2, input logic [7:0] s, input exp_t e);
        @(posedge clk);
        #1;
        s_valid  = 1'b1;
        s_y1     = y1;
        s_y2     = y2;
        s_side   = s;
        next_exp = e;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) check("accept_timeout", s_ready, 1);
    endtask

    task automatic send(input shortint y1, input shortint y2, input logic [7:0] s, input exp_t e);
        drive(y1, y2, s, e);
        wait_accept();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base_in, base_out;
        shortint x1, x2, y1, y2;
        logic [7:0] sd;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_s_ready", s_ready, 1);
        check("reset_m_valid", m_valid, 0);

        // Spec vectors, then back-to-back model-checked beats at full rate.
        send(256, 0, 8'd1, lit(182, 181, 8'd1));
        send(0, -1, 8'd2, lit(2, -1, 8'd2));
        send(32767, 32767, 8'd3, lit(27148, -19194, 8'd3));
        send(-32768, 100, 8'd4, inv_model(-32768, 100, 8'd4));
        send(1000, -2000, 8'd5, inv_model(1000, -2000, 8'd5));
        send(-1, -1, 8'd6, inv_model(-1, -1, 8'd6));
        send(-32768, -32768, 8'd7, inv_model(-32768, -32768, 8'd7));
        idle();
        wait_drain();
        check("directed_count", n_out, 7);

        // Backpressure from reset: five beats fill skid + stages.
        lat_chk = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        ready_val = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 5; i++)
            send(shortint'(100 * i), shortint'(-37 * i), 8'(10 + i),
                 inv_model(shortint'(100 * i), shortint'(-37 * i), 8'(10 + i)));
        drive(500, 600, 8'd15, inv_model(500, 600, 8'd15));
        @(negedge clk);
        check("bp_ready_low", s_ready, 0);
        repeat (5) @(negedge clk);
        check("bp_accepted", n_in - base_in, 5);
        check("bp_no_out", n_out - base_out, 0);
        check("bp_ready_still_low", s_ready, 0);
        out_cycs.delete();
        @(posedge clk);
        #1 ready_val = 1'b1;
        wait_accept();
        send(-700, 800, 8'd16, inv_model(-700, 800, 8'd16));
        send(900, -900, 8'd17, inv_model(900, -900, 8'd17));
        idle();
        wait_drain();
        check("bp_out_total", out_cycs.size(), 8);
        for (int i = 1; i < 5 && i < out_cycs.size(); i++)
            check("bp_consecutive", out_cycs[i] - out_cycs[i-1], 1);

        // Reset with three beats in flight; a beat offered during reset is ignored.
        lat_chk = 1'b1;
        send(11, 22, 8'd20, inv_model(11, 22, 8'd20));
        send(33, 44, 8'd21, inv_model(33, 44, 8'd21));
        send(55, 66, 8'd22, inv_model(55, 66, 8'd22));
        base_out = n_out;
        drive(1234, -4321, 8'd30, inv_model(1234, -4321, 8'd30));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 1);
        idle();
        wait_drain();
        check("rst_single_out", n_out - base_out, 1);

        // Round trip through the forward model with random valid/ready.
        lat_chk    = 1'b0;
        rand_ready = 1'b1;
        base_out   = n_out;
        for (int i = 0; i < 10000; i++) begin
            x1 = shortint'($urandom);
            x2 = shortint'($urandom);
            sd = 8'(i);
            fwd(x1, x2, y1, y2);
            if ($urandom_range(0, 3) == 0) idle();
            send(y1, y2, sd, lit(x1, x2, sd));
        end
        idle();
        rand_ready = 1'b0;
        wait_drain();
        check("rt_count", n_out - base_out, 10000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
